// File: rtl/prio_intr_ctrl.sv
// prio_intr_ctrl
//   Parametrised priority interrupt controller. Each of NUM_SRC interrupt
//   lines feeds a pending bit, either level-following or edge-latched. The
//   highest-priority eligible source is presented to the CPU one at a time
//   over a valid/ack/done handshake. Priority, enable, mode, pending clear
//   and the delivery threshold are programmed through an APB slave port.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   psel .. pslverr     APB slave (zero wait states, error on illegal address)
//                       paddr[ADDR_W-1:ADDR_W-2] selects the region:
//                         0 priority, 1 {edge_mode,enable}, 2 pending, 3 threshold
//                       paddr[IDX_W-1:0] selects the source
//   intr_src            raw interrupt lines, synchronous to clk
//   intr_valid          an interrupt is being presented to the CPU
//   intr_id, intr_prio  index and priority of the presented source
//   intr_ack            CPU claims the presented interrupt
//   intr_done           CPU has finished servicing the claimed interrupt
//   busy                a claimed interrupt is in service

module prio_intr_ctrl #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 4,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = $clog2(NUM_SRC),
    parameter int ADDR_W  = IDX_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [DATA_W-1:0]  pwdata,
    output logic [DATA_W-1:0]  prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [NUM_SRC-1:0] intr_src,
    output logic               intr_valid,
    output logic [IDX_W-1:0]   intr_id,
    output logic [PRIO_W-1:0]  intr_prio,
    input  logic               intr_ack,
    input  logic               intr_done,
    output logic               busy
);

    localparam logic [1:0] REG_PRIO = 2'd0;
    localparam logic [1:0] REG_MODE = 2'd1;
    localparam logic [1:0] REG_PEND = 2'd2;
    localparam logic [1:0] REG_THR  = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_VALID   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] edge_mode_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] src_q;
    logic [PRIO_W-1:0]  threshold_q;

    logic [1:0]         state_q;
    logic [IDX_W-1:0]   id_q;
    logic [PRIO_W-1:0]  prio_out_q;

    logic               apb_access;
    logic [1:0]         apb_region;
    logic [IDX_W-1:0]   apb_idx;
    logic               idx_oob;
    logic               apb_illegal;
    logic               apb_wr;

    logic [NUM_SRC-1:0] edge_rise;
    logic [NUM_SRC-1:0] apb_clr;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] eligible;
    logic               sel_eligible;

    logic               win_found;
    logic [IDX_W-1:0]   win_id;
    logic [PRIO_W-1:0]  win_prio;

    logic               unused_pwdata;

    // Only pwdata[PRIO_W-1:0] and pwdata[1:0] carry register content.
    assign unused_pwdata = ^pwdata;

    // APB decode. Only NUM_SRC sources exist, and the threshold region has a
    // single register at index 0; anything else is an error and is not written.
    assign apb_access  = psel & penable;
    assign apb_region  = paddr[ADDR_W-1:ADDR_W-2];
    assign apb_idx     = paddr[IDX_W-1:0];
    assign idx_oob     = ({1'b0, apb_idx} >= (IDX_W+1)'(NUM_SRC));
    assign apb_illegal = idx_oob | ((apb_region == REG_THR) && (apb_idx != '0));
    assign apb_wr      = apb_access & pwrite & ~apb_illegal;

    assign pready  = 1'b1;
    assign pslverr = apb_access & apb_illegal;

    // Read mux: data is only driven during a legal access phase, and bits not
    // backed by a register read as zero.
    always_comb begin
        prdata = '0;
        if (apb_access && !apb_illegal) begin
            case (apb_region)
                REG_PRIO: prdata[PRIO_W-1:0] = prio_q[apb_idx];
                REG_MODE: prdata[1:0]        = {edge_mode_q[apb_idx], enable_q[apb_idx]};
                REG_PEND: prdata[0]          = pending_q[apb_idx];
                default:  prdata[PRIO_W-1:0] = threshold_q;
            endcase
        end
    end

    // Configuration registers written over APB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
            enable_q    <= '0;
            edge_mode_q <= '0;
            threshold_q <= '0;
        end else if (apb_wr) begin
            case (apb_region)
                REG_PRIO: prio_q[apb_idx] <= pwdata[PRIO_W-1:0];
                REG_MODE: begin
                    edge_mode_q[apb_idx] <= pwdata[1];
                    enable_q[apb_idx]    <= pwdata[0];
                end
                REG_THR:  threshold_q <= pwdata[PRIO_W-1:0];
                default:  ;
            endcase
        end
    end

    // Pending clear requests: an APB write of 1 to the pending region, or the
    // CPU acknowledging the presented source. Both only affect edge sources.
    always_comb begin
        apb_clr = '0;
        ack_clr = '0;
        if (apb_wr && (apb_region == REG_PEND) && pwdata[0]) begin
            apb_clr[apb_idx] = 1'b1;
        end
        if ((state_q == ST_VALID) && intr_ack) begin
            ack_clr[id_q] = 1'b1;
        end
    end

    // The rising edge is taken between the incoming line and its registered
    // copy, so an edge appears in pending on the first clock that sees it.
    // A new edge in the same cycle as a clear keeps the bit set so no
    // interrupt is lost. Level sources simply follow the registered line.
    assign edge_rise = intr_src & ~src_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q <= intr_src;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (edge_mode_q[i]) begin
                    pending_q[i] <= edge_rise[i] |
                                    (pending_q[i] & ~(apb_clr[i] | ack_clr[i]));
                end else begin
                    pending_q[i] <= intr_src[i];
                end
            end
        end
    end

    // Arbitration: highest priority wins; the strict comparison while scanning
    // upward means the lowest index keeps a tie.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
            if (eligible[i] && (!win_found || (prio_q[i] > win_prio))) begin
                win_found = 1'b1;
                win_id    = IDX_W'(i);
                win_prio  = prio_q[i];
            end
        end
    end

    assign sel_eligible = eligible[id_q];

    // Delivery FSM. While presenting, the chosen source is frozen (no
    // preemption); it is withdrawn if it stops being eligible, but an ack in
    // the same cycle takes precedence over the withdrawal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            prio_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q    <= ST_VALID;
                        id_q       <= win_id;
                        prio_out_q <= win_prio;
                    end
                end
                ST_VALID: begin
                    if (intr_ack) begin
                        state_q <= ST_SERVICE;
                    end else if (!sel_eligible) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (intr_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign intr_valid = (state_q == ST_VALID);
    assign busy       = (state_q == ST_SERVICE);
    assign intr_id    = id_q;
    assign intr_prio  = prio_out_q;

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// tb_prio_intr_ctrl
//   Directed testbench for prio_intr_ctrl with NUM_SRC=16, PRIO_W=4, DATA_W=8.
//   Each scenario task drives its own stimulus and compares against
//   hand-computed values. Inputs change on the falling edge and outputs are
//   observed on the falling edge, away from the active rising edge.

module tb_prio_intr_ctrl;

    localparam int NUM_SRC = 16;
    localparam int PRIO_W  = 4;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 4;
    localparam int ADDR_W  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;
    logic [DATA_W-1:0]  prdata;
    logic               pready;
    logic               pslverr;
    logic [NUM_SRC-1:0] intr_src;
    logic               intr_valid;
    logic [IDX_W-1:0]   intr_id;
    logic [PRIO_W-1:0]  intr_prio;
    logic               intr_ack;
    logic               intr_done;
    logic               busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    prio_intr_ctrl #(
        .NUM_SRC(NUM_SRC),
        .PRIO_W (PRIO_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .intr_src  (intr_src),
        .intr_valid(intr_valid),
        .intr_id   (intr_id),
        .intr_prio (intr_prio),
        .intr_ack  (intr_ack),
        .intr_done (intr_done),
        .busy      (busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One rising edge, returning on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apb_write(input logic [1:0] region, input logic [3:0] idx,
                             input logic [7:0] data, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = {region, idx};
        pwdata  = data;
        tick();
        penable = 1'b1;
        #1;
        err = pslverr;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] region, input logic [3:0] idx,
                            output logic [7:0] data, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = {region, idx};
        tick();
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic pulse_src(input logic [15:0] mask);
        intr_src = mask;
        tick();
        intr_src = '0;
    endtask

    task automatic pulse_ack();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
    endtask

    task automatic pulse_done();
        intr_done = 1'b1;
        tick();
        intr_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       e;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio, busy} !== 10'd0) begin
            err_cnt++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {intr_valid, intr_id, intr_prio, busy}, 10'd0);
        end
        vec_cnt++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 8'h00}) begin
            err_cnt++;
            $display("[TB] FAIL reset_apb: got %b expected %b",
                     {pready, pslverr, prdata}, {1'b1, 1'b0, 8'h00});
        end
        apb_read(2'd0, 4'd3, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h000) begin
            err_cnt++;
            $display("[TB] FAIL reset_prio3: got %h expected %h", {e, d}, 9'h000);
        end
        apb_read(2'd3, 4'd0, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h000) begin
            err_cnt++;
            $display("[TB] FAIL reset_threshold: got %h expected %h", {e, d}, 9'h000);
        end
    endtask

    task automatic test_priority_order();
        logic [7:0] d;
        logic       e;
        for (int i = 0; i < 16; i++) begin
            apb_write(2'd0, 4'(i), 8'(i), e);
            apb_write(2'd1, 4'(i), 8'h03, e);
        end
        apb_read(2'd1, 4'd7, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h003) begin
            err_cnt++;
            $display("[TB] FAIL mode_readback: got %h expected %h", {e, d}, 9'h003);
        end
        pulse_src(16'h1088);
        vec_cnt++;
        if (intr_valid !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL prio_latency: got %b expected %b", intr_valid, 1'b0);
        end
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd12, 4'd12}) begin
            err_cnt++;
            $display("[TB] FAIL prio_first: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd12, 4'd12});
        end
        pulse_done();
        vec_cnt++;
        if ({intr_valid, busy, intr_id} !== {1'b1, 1'b0, 4'd12}) begin
            err_cnt++;
            $display("[TB] FAIL done_in_valid: got %b expected %b",
                     {intr_valid, busy, intr_id}, {1'b1, 1'b0, 4'd12});
        end
        pulse_ack();
        vec_cnt++;
        if ({intr_valid, busy} !== 2'b01) begin
            err_cnt++;
            $display("[TB] FAIL ack_service: got %b expected %b", {intr_valid, busy}, 2'b01);
        end
        apb_read(2'd2, 4'd12, d, e);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++;
            $display("[TB] FAIL ack_clears_pending: got %h expected %h", d, 8'h00);
        end
        apb_read(2'd2, 4'd7, d, e);
        vec_cnt++;
        if (d !== 8'h01) begin
            err_cnt++;
            $display("[TB] FAIL other_pending: got %h expected %h", d, 8'h01);
        end
        pulse_done();
        vec_cnt++;
        if ({intr_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL done_idle: got %b expected %b", {intr_valid, busy}, 2'b00);
        end
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd7, 4'd7}) begin
            err_cnt++;
            $display("[TB] FAIL prio_second: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd7, 4'd7});
        end
        pulse_ack();
        pulse_done();
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd3, 4'd3}) begin
            err_cnt++;
            $display("[TB] FAIL prio_third: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd3, 4'd3});
        end
        pulse_ack();
        pulse_done();
        tick();
        tick();
        vec_cnt++;
        if ({intr_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL prio_drained: got %b expected %b", {intr_valid, busy}, 2'b00);
        end
    endtask

    task automatic test_tie();
        logic e;
        apb_write(2'd0, 4'd2, 8'h05, e);
        apb_write(2'd0, 4'd9, 8'h05, e);
        pulse_src(16'h0204);
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd2, 4'd5}) begin
            err_cnt++;
            $display("[TB] FAIL tie_first: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd2, 4'd5});
        end
        pulse_ack();
        pulse_done();
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd9, 4'd5}) begin
            err_cnt++;
            $display("[TB] FAIL tie_second: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd9, 4'd5});
        end
        pulse_ack();
        pulse_done();
        tick();
    endtask

    task automatic test_threshold();
        logic e;
        apb_write(2'd0, 4'd4, 8'h06, e);
        apb_write(2'd3, 4'd0, 8'h06, e);
        pulse_src(16'h0010);
        tick();
        tick();
        tick();
        vec_cnt++;
        if (intr_valid !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL thr_equal_blocks: got %b expected %b", intr_valid, 1'b0);
        end
        apb_write(2'd3, 4'd0, 8'h05, e);
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd4, 4'd6}) begin
            err_cnt++;
            $display("[TB] FAIL thr_lowered: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd4, 4'd6});
        end
        pulse_ack();
        pulse_done();
        apb_write(2'd3, 4'd0, 8'h00, e);
        vec_cnt++;
        if (intr_valid !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL thr_after: got %b expected %b", intr_valid, 1'b0);
        end
    endtask

    task automatic test_level();
        logic e;
        apb_write(2'd1, 4'd5, 8'h01, e);
        intr_src = 16'h0020;
        tick();
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd5, 4'd5}) begin
            err_cnt++;
            $display("[TB] FAIL level_present: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd5, 4'd5});
        end
        pulse_ack();
        pulse_done();
        vec_cnt++;
        if ({intr_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL level_done: got %b expected %b", {intr_valid, busy}, 2'b00);
        end
        tick();
        vec_cnt++;
        if ({intr_valid, intr_id} !== {1'b1, 4'd5}) begin
            err_cnt++;
            $display("[TB] FAIL level_represent: got %h expected %h",
                     {intr_valid, intr_id}, {1'b1, 4'd5});
        end
        intr_src = '0;
        tick();
        tick();
        vec_cnt++;
        if ({intr_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL level_withdraw: got %b expected %b", {intr_valid, busy}, 2'b00);
        end
        tick();
        vec_cnt++;
        if (intr_valid !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL level_stays_idle: got %b expected %b", intr_valid, 1'b0);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] d;
        logic       e;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = {2'd2, 4'd1};
        pwdata  = 8'h01;
        tick();
        penable  = 1'b1;
        intr_src = 16'h0002;
        tick();
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        intr_src = '0;
        apb_read(2'd2, 4'd1, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h001) begin
            err_cnt++;
            $display("[TB] FAIL set_wins_pending: got %h expected %h", {e, d}, 9'h001);
        end
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio} !== {1'b1, 4'd1, 4'd1}) begin
            err_cnt++;
            $display("[TB] FAIL set_wins_valid: got %h expected %h",
                     {intr_valid, intr_id, intr_prio}, {1'b1, 4'd1, 4'd1});
        end
        apb_write(2'd2, 4'd1, 8'h01, e);
        tick();
        vec_cnt++;
        if ({intr_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("[TB] FAIL clear_withdraw: got %b expected %b", {intr_valid, busy}, 2'b00);
        end
        apb_read(2'd2, 4'd1, d, e);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++;
            $display("[TB] FAIL clear_pending: got %h expected %h", d, 8'h00);
        end
    endtask

    task automatic test_errors();
        logic [7:0] d;
        logic       e;
        apb_read(2'd3, 4'd1, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h100) begin
            err_cnt++;
            $display("[TB] FAIL err_read: got %h expected %h", {e, d}, 9'h100);
        end
        apb_write(2'd3, 4'd1, 8'h07, e);
        vec_cnt++;
        if (e !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL err_write: got %b expected %b", e, 1'b1);
        end
        apb_read(2'd3, 4'd0, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h000) begin
            err_cnt++;
            $display("[TB] FAIL err_write_ignored: got %h expected %h", {e, d}, 9'h000);
        end
        apb_read(2'd0, 4'd9, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h005) begin
            err_cnt++;
            $display("[TB] FAIL prio9_read: got %h expected %h", {e, d}, 9'h005);
        end
        apb_read(2'd1, 4'd5, d, e);
        vec_cnt++;
        if ({e, d} !== 9'h001) begin
            err_cnt++;
            $display("[TB] FAIL mode5_read: got %h expected %h", {e, d}, 9'h001);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       e;
        pulse_src(16'h1000);
        tick();
        pulse_ack();
        vec_cnt++;
        if ({busy, intr_id} !== {1'b1, 4'd12}) begin
            err_cnt++;
            $display("[TB] FAIL mid_service: got %h expected %h", {busy, intr_id}, {1'b1, 4'd12});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++;
        if ({intr_valid, intr_id, intr_prio, busy} !== 10'd0) begin
            err_cnt++;
            $display("[TB] FAIL mid_reset_outputs: got %b expected %b",
                     {intr_valid, intr_id, intr_prio, busy}, 10'd0);
        end
        apb_read(2'd0, 4'd12, d, e);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++;
            $display("[TB] FAIL mid_reset_prio: got %h expected %h", d, 8'h00);
        end
        apb_read(2'd1, 4'd12, d, e);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++;
            $display("[TB] FAIL mid_reset_mode: got %h expected %h", d, 8'h00);
        end
        apb_read(2'd2, 4'd12, d, e);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++;
            $display("[TB] FAIL mid_reset_pending: got %h expected %h", d, 8'h00);
        end
    endtask

    initial begin
        rst       = 1'b1;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        intr_src  = '0;
        intr_ack  = 1'b0;
        intr_done = 1'b0;
        @(negedge clk);
        $display("[TB] starting prio_intr_ctrl directed tests");
        test_reset();
        test_priority_order();
        test_tie();
        test_threshold();
        test_level();
        test_set_wins();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
